cordic_log: RTL and testbench

Iterative shift-add CORDIC unit that computes result = -log2(y) for an unsigned fractional input y. It is the inverse of the pipelined 2^-x CORDIC kernel and is used to map kernel-domain values back to exponent form, e.g. for SVM kernel calibration and gamma estimation. It processes one operand at a time through a NORM/ITER/DONE state machine with valid/ready handshakes on both sides.

---
 rtl/cordic_log.sv | 132 +++++++++++++
 tb/tb_cordic_log.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_log.sv
// Iterative shift-add CORDIC computing result = -log2(y) for an unsigned 0.WIDTH fraction.
// y is normalised into [0.5,1) and then multiplied up towards 1.0 by (1+2^-k) factors.
module cordic_log #(
    parameter int WIDTH       = 16,
    parameter int INTER_WIDTH = 24,
    parameter int STEPS       = 16,
    parameter int INT_WIDTH   = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INT_WIDTH+WIDTH-1:0] result,
    output logic                       zero_err
);

    localparam int RW  = INT_WIDTH + WIDTH;
    localparam int KW  = $clog2(STEPS + 1);
    localparam int PAD = INTER_WIDTH - WIDTH;

    typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

    state_t               state, state_nxt;
    logic [INTER_WIDTH:0] z, z_nxt, e, e_nxt, cand;
    logic [INT_WIDTH-1:0] n, n_nxt;
    logic [KW-1:0]        k, k_nxt;
    logic [RW-1:0]        result_nxt;
    logic                 zero_err_nxt;
    logic [INTER_WIDTH:0] log_tab [0:STEPS];

    // log2(1+2^-k) in 1.INTER_WIDTH, rounded to nearest; entry 0 is never used
    assign log_tab[0] = '0;
    for (genvar gi = 1; gi <= STEPS; gi++) begin : g_rom
        localparam real LOG_REAL = $ln(1.0 + 2.0 ** (-gi)) / $ln(2.0) * (2.0 ** INTER_WIDTH);
        localparam logic [INTER_WIDTH:0] LOG_VAL = (INTER_WIDTH+1)'($rtoi(LOG_REAL + 0.5));
        assign log_tab[gi] = LOG_VAL;
    end

    assign in_ready = (state == IDLE) && !reset;

    // next-state and datapath update for the NORM/ITER/DONE sequence
    always_comb begin
        state_nxt    = state;
        z_nxt        = z;
        e_nxt        = e;
        n_nxt        = n;
        k_nxt        = k;
        result_nxt   = result;
        zero_err_nxt = zero_err;
        cand         = z + (z >> k);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    z_nxt        = {1'b0, y, {PAD{1'b0}}};
                    n_nxt        = '0;
                    e_nxt        = '0;
                    k_nxt        = '0;
                    zero_err_nxt = 1'b0;
                    state_nxt    = NORM;
                end else begin
                    state_nxt = IDLE;
                end
            end
            NORM: begin
                if (z == '0) begin
                    zero_err_nxt = 1'b1;
                    result_nxt   = '1;
                    state_nxt    = DONE;
                end else if (!z[INTER_WIDTH-1]) begin
                    z_nxt = z << 1;
                    n_nxt = n + INT_WIDTH'(1);
                end else begin
                    k_nxt     = KW'(1);
                    state_nxt = ITER;
                end
            end
            ITER: begin
                // a candidate reaching exactly 1.0 is rejected along with anything larger
                if (!cand[INTER_WIDTH]) begin
                    z_nxt = cand;
                    e_nxt = e + log_tab[k];
                end else begin
                    z_nxt = z;
                end
                k_nxt = k + KW'(1);
                if (k == KW'(STEPS)) begin
                    result_nxt = (RW'(n) << WIDTH) + RW'(e_nxt >> PAD);
                    state_nxt  = DONE;
                end else begin
                    state_nxt = ITER;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // state, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            z         <= '0;
            e         <= '0;
            n         <= '0;
            k         <= '0;
            result    <= '0;
            zero_err  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            z         <= z_nxt;
            e         <= e_nxt;
            n         <= n_nxt;
            k         <= k_nxt;
            result    <= result_nxt;
            zero_err  <= zero_err_nxt;
            out_valid <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_cordic_log.sv
// Self-checking bench for cordic_log: directed cases, backpressure, mid-op reset
// and a random sweep against a real-valued -log2 reference.
module tb_cordic_log;

    localparam int WIDTH       = 16;
    localparam int INTER_WIDTH = 24;
    localparam int STEPS       = 16;
    localparam int INT_WIDTH   = 5;
    localparam int RW          = INT_WIDTH + WIDTH;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  y;
    logic              out_valid;
    logic              out_ready;
    logic [RW-1:0]     result;
    logic              zero_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cordic_log #(
        .WIDTH(WIDTH), .INTER_WIDTH(INTER_WIDTH), .STEPS(STEPS), .INT_WIDTH(INT_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .y(y),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero_err(zero_err)
    );

    task automatic check(input string tag, input longint obs, input real exp, input real tol);
        real d;
        tests++;
        d = real'(obs) - exp;
        if (d < 0.0) d = -d;
        if (d > tol) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), want %0.3f +/- %0.1f", tag, obs, obs, exp, tol);
        end
    endtask

    function automatic real ideal(input int yv);
        return -$ln(real'(yv) / 65536.0) / $ln(2.0) * 65536.0;
    endfunction

    function automatic int lead_zeros(input int yv);
        int c = 0;
        for (int b = WIDTH - 1; b >= 0; b--) begin
            if (yv[b]) break;
            c++;
        end
        return c;
    endfunction

    // Leaves the bench #1 after the accepting edge.
    task automatic accept(input logic [WIDTH-1:0] yv);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("accept_ready", in_ready, 1.0, 0.0);
        in_valid = 1'b1;
        y        = yv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        y        = WIDTH'($urandom);
        check("zerr_clear", zero_err, 0.0, 0.0);
    endtask

    // Called #1 after the accepting edge (edge 1).
    task automatic collect(input logic [WIDTH-1:0] yv, input bit handoff);
        int  lat = 1;
        real exp_r, tol;
        int  exp_z, exp_lat;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            check("timeout", out_valid, 1.0, 0.0);
            return;
        end
        if (yv == '0) begin
            exp_r = 2097151.0; tol = 0.0; exp_z = 1; exp_lat = 2;
        end else begin
            exp_r = ideal(int'(yv)); tol = 4.0; exp_z = 0;
            exp_lat = lead_zeros(int'(yv)) + STEPS + 2;
        end
        check("latency", lat, real'(exp_lat), 0.0);
        check("result", result, exp_r, tol);
        check("zero_err", zero_err, real'(exp_z), 0.0);
        if (handoff) begin
            @(posedge clk); #1;
            check("handoff", out_valid, 0.0, 0.0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] dir_y [7] = '{16'hFFFF, 16'hB505, 16'h8000, 16'h4000,
                                        16'h0001, 16'h0000, 16'h1234};
        longint r0;
        int     seen;
        logic [WIDTH-1:0] yv;

        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; y = 16'h8000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0.0, 0.0);
        check("rst_out_valid", out_valid, 0.0, 0.0);
        check("rst_result", result, 0.0, 0.0);
        check("rst_zero_err", zero_err, 0.0, 0.0);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1.0, 0.0);

        foreach (dir_y[i]) begin
            accept(dir_y[i]);
            collect(dir_y[i], 1'b1);
        end

        // backpressure in DONE
        out_ready = 1'b0;
        accept(16'h4000);
        collect(16'h4000, 1'b0);
        r0 = longint'(result);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            y        = WIDTH'($urandom);
            @(posedge clk); #1;
            check("bp_hold", result, real'(r0), 0.0);
            check("bp_ready", in_ready, 0.0, 0.0);
            check("bp_valid", out_valid, 1.0, 0.0);
        end
        y = 16'h2000;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_idle", in_ready, 1.0, 0.0);
        check("release_valid", out_valid, 0.0, 0.0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        y        = WIDTH'($urandom);
        check("accept_once", in_ready, 0.0, 0.0);
        collect(16'h2000, 1'b1);

        // reset in the middle of ITER
        accept(16'h9000);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_ready", in_ready, 1.0, 0.0);
        check("abort_valid", out_valid, 0.0, 0.0);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_output", seen, 0.0, 0.0);
        accept(16'hC000);
        collect(16'hC000, 1'b1);

        // random sweep, biased to cover every normalisation depth
        for (int i = 0; i < 1500; i++) begin
            yv = WIDTH'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            accept(yv);
            collect(yv, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
